// File: rtl/led_slot_scheduler.sv
// Time-shared PWM LED scheduler: serves one enabled LED per slot,
// round-robin, with a shadow duty array written over a simple cfg port.
module led_slot_scheduler #(
   parameter int PWM_BITS = 10,
   parameter int NUM_LEDS = 5
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                CFG_WE,
   input  logic [2:0]          CFG_ADDR,
   input  logic [PWM_BITS-1:0] CFG_DUTY,
   output logic                CFG_ACK,
   output logic                CFG_ERR,
   output logic [NUM_LEDS-1:0] LED,
   output logic [2:0]          SLOT,
   output logic                FRAME_DONE
);

   typedef enum logic [1:0] {IDLE, SELECT, ACTIVE} state_t;

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
   localparam logic [3:0]          NL      = 4'(NUM_LEDS);

   state_t              state, state_nx;
   logic [PWM_BITS-1:0] shadow [NUM_LEDS];
   logic [PWM_BITS-1:0] active_duty;
   logic [PWM_BITS-1:0] cnt;
   logic [2:0]          ptr;
   logic [NUM_LEDS-1:0] nz;
   logic [3:0]          sel;
   logic [3:0]          nxt;
   logic [2:0]          slot_inc;
   logic                slot_end;
   logic                addr_ok;

   function automatic logic [2:0] wrap(input logic [3:0] v);
      logic [3:0] r;
      r = (v >= NL) ? v - NL : v;
      return r[2:0];
   endfunction

   // {found, index} of the first nonzero duty at or after start
   function automatic logic [3:0] find_nz(
      input logic [NUM_LEDS-1:0] nzv,
      input logic [2:0]          start
   );
      logic [3:0] r;
      logic [2:0] p;
      r = '0;
      for (int k = NUM_LEDS - 1; k >= 0; k--) begin
         p = wrap({1'b0, start} + 4'(k));
         if (nzv[p]) r = {1'b1, p};
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_LEDS; i++) nz[i] = |shadow[i];
   end

   assign addr_ok  = ({1'b0, CFG_ADDR} < NL);
   assign slot_inc = wrap({1'b0, SLOT} + 4'd1);
   assign sel      = find_nz(nz, ptr);
   assign nxt      = find_nz(nz, slot_inc);
   assign slot_end = (state == ACTIVE) && (cnt == CNT_MAX);

   always_comb begin
      state_nx   = state;
      LED        = '0;
      FRAME_DONE = 1'b0;
      unique case (state)
         IDLE: begin
            if (EN && (|nz)) state_nx = SELECT;
         end
         SELECT: begin
            state_nx = sel[3] ? ACTIVE : IDLE;
         end
         ACTIVE: begin
            LED[SLOT] = (cnt < active_duty);
            if (cnt == CNT_MAX) begin
               state_nx   = EN ? SELECT : IDLE;
               FRAME_DONE = !EN || !nxt[3] || (nxt[2:0] <= SLOT);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         ptr         <= '0;
         SLOT        <= '0;
         cnt         <= '0;
         active_duty <= '0;
         CFG_ACK     <= 1'b0;
         CFG_ERR     <= 1'b0;
         for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= '0;
      end else begin
         state   <= state_nx;
         CFG_ACK <= CFG_WE;
         CFG_ERR <= CFG_WE && !addr_ok;
         if (CFG_WE && addr_ok) shadow[CFG_ADDR] <= CFG_DUTY;
         unique case (state)
            IDLE: ptr <= '0;
            SELECT: begin
               if (sel[3]) begin
                  SLOT        <= sel[2:0];
                  active_duty <= shadow[sel[2:0]];
                  cnt         <= '0;
               end
            end
            ACTIVE: begin
               cnt <= cnt + 1'b1;
               if (slot_end) ptr <= slot_inc;
            end
            default: ptr <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_led_slot_scheduler.sv
// Bench for led_slot_scheduler: write-port vector table, directed corner
// sequences, and random duty sets against a slot-level schedule model.
module tb_led_slot_scheduler;

   localparam int PW = 4;
   localparam int NL = 5;
   localparam int SL = 1 << PW;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          EN = 1'b0;
   logic          CFG_WE = 1'b0;
   logic [2:0]    CFG_ADDR = '0;
   logic [PW-1:0] CFG_DUTY = '0;
   logic          CFG_ACK;
   logic          CFG_ERR;
   logic [NL-1:0] LED;
   logic [2:0]    SLOT;
   logic          FRAME_DONE;

   int checks = 0;
   int failures = 0;
   int md [NL];

   typedef struct {
      logic       we;
      logic [2:0] addr;
      logic [3:0] duty;
      logic       ack;
      logic       err;
   } vec_t;

   typedef struct {
      logic [NL-1:0] led;
      int            slot;
      logic          fd;
      bit            cs;
   } exp_t;

   vec_t tbl [8];
   exp_t q [$];

   led_slot_scheduler #(.PWM_BITS(PW), .NUM_LEDS(NL)) dut (
      .CLK(CLK),
      .RST(RST),
      .EN(EN),
      .CFG_WE(CFG_WE),
      .CFG_ADDR(CFG_ADDR),
      .CFG_DUTY(CFG_DUTY),
      .CFG_ACK(CFG_ACK),
      .CFG_ERR(CFG_ERR),
      .LED(LED),
      .SLOT(SLOT),
      .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int first_nz(input int from);
      for (int k = 0; k < NL; k++)
         if (md[(from + k) % NL] != 0) return (from + k) % NL;
      return -1;
   endfunction

   function automatic int last_nz();
      int r;
      r = -1;
      for (int i = 0; i < NL; i++) if (md[i] != 0) r = i;
      return r;
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      EN = 1'b0;
      CFG_WE = 1'b0;
      #1;
      chk("rst_led", int'(LED), 0);
      chk("rst_slot", int'(SLOT), 0);
      chk("rst_fd", int'(FRAME_DONE), 0);
      chk("rst_ack", int'(CFG_ACK), 0);
      chk("rst_err", int'(CFG_ERR), 0);
      step();
      RST = 1'b0;
      for (int i = 0; i < NL; i++) md[i] = 0;
   endtask

   task automatic set_duty(input int a, input int d);
      CFG_WE = 1'b1;
      CFG_ADDR = 3'(a);
      CFG_DUTY = PW'(d);
      step();
      chk("wr_ack", int'(CFG_ACK), 1);
      chk("wr_err", int'(CFG_ERR), 0);
      CFG_WE = 1'b0;
      md[a] = d;
   endtask

   // Expected per-cycle stream: select cycle, then a full slot per LED
   task automatic build(input int n);
      int idx, last;
      exp_t e;
      q.delete();
      idx = first_nz(0);
      last = last_nz();
      while (q.size() < n) begin
         e.led = '0; e.slot = 0; e.fd = 1'b0; e.cs = 1'b0;
         q.push_back(e);
         if (idx >= 0) begin
            for (int c = 0; c < SL; c++) begin
               e.led = '0;
               if (c < md[idx]) e.led[idx] = 1'b1;
               e.slot = idx;
               e.fd = (c == SL - 1) && (idx == last);
               e.cs = 1'b1;
               q.push_back(e);
            end
            idx = first_nz((idx + 1) % NL);
         end
      end
   endtask

   task automatic run_check(input int n, input bit rnd);
      bit pw;
      exp_t e;
      build(n);
      EN = 1'b1;
      pw = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         e = q[i];
         chk("led", int'(LED), int'(e.led));
         chk("frame_done", int'(FRAME_DONE), int'(e.fd));
         if (e.cs) chk("slot", int'(SLOT), e.slot);
         chk("ack", int'(CFG_ACK), int'(pw));
         if (pw) chk("err", int'(CFG_ERR), 1);
         pw = rnd && ($urandom % 4 == 0);
         CFG_WE = pw;
         CFG_ADDR = 3'($urandom_range(5, 7));
         CFG_DUTY = PW'($urandom);
      end
      CFG_WE = 1'b0;
      EN = 1'b0;
   endtask

   initial begin
      int hi, bad;
      bit found;

      tbl[0] = '{1'b1, 3'd0, 4'd3,  1'b1, 1'b0};
      tbl[1] = '{1'b1, 3'd6, 4'd9,  1'b1, 1'b1};
      tbl[2] = '{1'b1, 3'd3, 4'd15, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 3'd7, 4'd1,  1'b1, 1'b1};
      tbl[4] = '{1'b0, 3'd1, 4'd7,  1'b0, 1'b0};
      tbl[5] = '{1'b1, 3'd4, 4'd1,  1'b1, 1'b0};
      tbl[6] = '{1'b1, 3'd5, 4'd2,  1'b1, 1'b1};
      tbl[7] = '{1'b1, 3'd2, 4'd0,  1'b1, 1'b0};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         CFG_WE = tbl[i].we;
         CFG_ADDR = tbl[i].addr;
         CFG_DUTY = tbl[i].duty;
         step();
         chk("tbl_ack", int'(CFG_ACK), int'(tbl[i].ack));
         chk("tbl_err", int'(CFG_ERR), int'(tbl[i].err));
         if (tbl[i].we && tbl[i].addr < NL) md[tbl[i].addr] = int'(tbl[i].duty);
      end
      CFG_WE = 1'b0;
      run_check(17 * 3 * 3, 1'b0);

      do_reset();
      set_duty(2, 5);
      run_check(17 * 4, 1'b1);

      // mid-slot rewrite of the served LED
      do_reset();
      set_duty(0, 3);
      EN = 1'b1;
      step();
      hi = 0;
      for (int c = 0; c < SL; c++) begin
         step();
         if (LED[0]) hi++;
         CFG_WE = (c == 4);
         CFG_ADDR = 3'd0;
         CFG_DUTY = 4'd8;
      end
      chk("shadow_hold_hi", hi, 3);
      step();
      chk("sel_led", int'(LED), 0);
      hi = 0;
      for (int c = 0; c < SL; c++) begin
         step();
         if (LED[0]) hi++;
      end
      chk("shadow_new_hi", hi, 8);
      EN = 1'b0;

      // EN drop mid-slot
      do_reset();
      set_duty(2, 5);
      EN = 1'b1;
      step();
      step();
      chk("cnt0_led", int'(LED), 4);
      for (int k = 1; k <= 6; k++) step();
      chk("cnt6_led", int'(LED), 0);
      EN = 1'b0;
      chk("cnt6_fd", int'(FRAME_DONE), 0);
      for (int k = 7; k < SL; k++) begin
         step();
         chk("drain_fd", int'(FRAME_DONE), int'(k == SL - 1));
         chk("drain_led", int'(LED), 0);
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (LED != 0 || FRAME_DONE) bad++;
      end
      chk("idle_quiet", bad, 0);

      // async reset mid-slot, write lost under reset
      do_reset();
      set_duty(2, 5);
      EN = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("cnt2_led", int'(LED), 4);
      #2;
      RST = 1'b1;
      CFG_WE = 1'b1;
      CFG_ADDR = 3'd1;
      CFG_DUTY = 4'd9;
      #1;
      chk("async_led", int'(LED), 0);
      @(posedge CLK);
      #1;
      chk("rst_wr_ack", int'(CFG_ACK), 0);
      RST = 1'b0;
      CFG_WE = 1'b0;
      for (int i = 0; i < NL; i++) md[i] = 0;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (LED != 0 || FRAME_DONE) bad++;
      end
      chk("post_rst_quiet", bad, 0);
      EN = 1'b0;
      step();
      set_duty(1, 9);
      run_check(40, 1'b0);

      // write coincident with slot end
      do_reset();
      set_duty(1, 4);
      EN = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (FRAME_DONE) found = 1'b1;
      end
      chk("end_found", int'(found), 1);
      CFG_WE = 1'b1;
      CFG_ADDR = 3'd3;
      CFG_DUTY = 4'd2;
      step();
      CFG_WE = 1'b0;
      chk("edge_sel_led", int'(LED), 0);
      step();
      chk("edge_slot", int'(SLOT), 3);
      chk("edge_led", int'(LED), 8);
      EN = 1'b0;

      for (int it = 0; it < 6; it++) begin
         do_reset();
         for (int i = 0; i < NL; i++)
            if ($urandom % 2 == 0) set_duty(i, int'($urandom_range(1, SL - 1)));
         run_check(200, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_slot_scheduler.md
LED_SLOT_SCHEDULER -- requirements
Module: led_slot_scheduler

Interface
REQ-001 Parameter PWM_BITS, default 10, SHALL set PWM counter and duty width; one slot lasts 2^PWM_BITS cycles.
REQ-002 Parameter NUM_LEDS, default 5, SHALL set the number of time-shared LED outputs; the legal range is 2..8.
REQ-003 Port CLK, input, 1: the only clock; all state updates occur on its rising edge.
REQ-004 Port RST, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 Port EN, input, 1: run request for the scheduler.
REQ-006 Port CFG_WE, input, 1: duty write strobe.
REQ-007 Port CFG_ADDR, input, 3: target LED index for the write.
REQ-008 Port CFG_DUTY, input, PWM_BITS: duty value to write.
REQ-009 Port CFG_ACK, output, 1: one-cycle write acknowledge.
REQ-010 Port CFG_ERR, output, 1: qualifies CFG_ACK; high when the address was out of range.
REQ-011 Port LED, output, NUM_LEDS: per-LED drive; bit i drives LED i.
REQ-012 Port SLOT, output, 3: index of the LED currently being served.
REQ-013 Port FRAME_DONE, output, 1: one-cycle pulse at the end of each round-robin frame.

Function
REQ-014 Duty storage SHALL be a shadow array of NUM_LEDS x PWM_BITS; a value of 0 SHALL mean the LED is disabled.
REQ-015 When CFG_WE=1 and CFG_ADDR<NUM_LEDS, the shadow entry SHALL be written.
REQ-016 The cycle after any CFG_WE=1, CFG_ACK SHALL be 1 and CFG_ERR SHALL equal (CFG_ADDR>=NUM_LEDS); the write SHALL be dropped when the address is out of range.
REQ-017 A write every cycle SHALL produce an ACK every cycle, one cycle delayed.
REQ-018 The FSM SHALL have three states: IDLE, SELECT, ACTIVE.
REQ-019 IDLE -> SELECT when EN=1 and any shadow duty is nonzero; the search pointer starts at index 0.
REQ-020 SELECT, which takes exactly 1 cycle, SHALL pick the first nonzero-duty index at or after the pointer, round-robin and wrapping NUM_LEDS-1 -> 0.
REQ-021 SELECT SHALL copy that LED's shadow duty into the active duty register, load SLOT, clear the counter and go to ACTIVE; if no duty is nonzero it SHALL return to IDLE.
REQ-022 In ACTIVE the counter SHALL increment each cycle; LED[SLOT] = (cnt < active_duty) and all other LED bits SHALL be 0.
REQ-023 Slot end occurs at cnt = 2^PWM_BITS-1: the pointer SHALL become SLOT+1 modulo NUM_LEDS and the FSM SHALL go to SELECT if EN=1, else IDLE.
REQ-024 LED SHALL be all-zero in IDLE and SELECT.
REQ-025 Shadow writes during ACTIVE SHALL NOT affect the current slot, including writes to the served LED; they take effect at the next SELECT.
REQ-026 Deasserting EN mid-slot SHALL let the slot complete, with no truncated PWM period.
REQ-027 FRAME_DONE SHALL pulse in the slot-end cycle when the next nonzero index, evaluated on the shadow array at that cycle, is <= SLOT (wrap, including the single-enabled-LED case), or when EN=0.
REQ-028 A simultaneous write and slot end SHALL resolve with the write visible to the following SELECT.
REQ-029 Duty = 2^PWM_BITS-1 SHALL give high for all but the final cycle of the slot; duty 1 SHALL give exactly 1 high cycle.

Reset
REQ-030 While RST=1, asynchronously: state IDLE, pointer 0, SLOT 0, cnt 0, all shadow and active duties 0, LED all 0, CFG_ACK 0, CFG_ERR 0, FRAME_DONE 0.
REQ-031 A write coincident with RST SHALL be lost and SHALL NOT be acknowledged.
REQ-032 RST asserted mid-slot SHALL force LED to 0 immediately, without waiting for a clock edge.
REQ-033 After RST falls, the block SHALL remain in IDLE until EN=1 and a nonzero duty has been written.

Verification (PWM_BITS=4, NUM_LEDS=5)
REQ-034 Write duty[2]=5, then EN=1 -> SELECT 1 cycle; LED=5'b00100 for 5 cycles, then 0 for 11 cycles, repeating; FRAME_DONE pulses every 17 cycles.
REQ-035 Write duty[0]=3, duty[3]=15, duty[4]=1, EN=1 -> SLOT sequence 0,3,4,0,...; LED[3] high for 15 of 16 cycles; FRAME_DONE only at the end of slot 4.
REQ-036 Write CFG_ADDR=6 -> next cycle CFG_ACK=1 and CFG_ERR=1; all duties are unchanged.
REQ-037 During slot 0 with duty[0]=3, write duty[0]=8 -> current slot 3 high cycles; next service of slot 0 gives 8 high cycles.
REQ-038 Drop EN at cnt=6 -> slot finishes at cnt=15, FRAME_DONE=1, then IDLE with LED=0.
REQ-039 Assert RST at cnt=2 of an active slot -> LED=0 asynchronously; after release, re-enabling with EN=1 yields no output until a duty is rewritten.
